// File: rtl/branch_ctrl_pkg.sv
// Shared types and defaults for the branch redirect controller.
// Optional statistics counter is enabled with BRANCH_CTRL_STATS_EN.
package branch_ctrl_pkg;

    localparam int BC_ADDR_W       = 32;
    localparam int BC_DRAIN_CYCLES = 2;
    localparam int BC_CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } bc_state_t;

endpackage

// File: rtl/branch_drain_cnt.sv
// Loadable down-counter that times the post-redirect bubble window.
// Flags report zero and the final (count==1) cycle.
module branch_drain_cnt
    import branch_ctrl_pkg::*;
#(
    parameter int W = BC_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);
    assign last = (cnt_q == W'(1));

endmodule

// File: rtl/branch_ctrl.sv
// Branch redirect controller: captures taken branches, hands the target to fetch.
// BRANCH_CTRL_STATS_EN adds a 32-bit accepted-branch counter output.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int ADDR         = BC_ADDR_W,
    parameter int DRAIN_CYCLES = BC_DRAIN_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_i,
    input  logic [ADDR-1:0] branch_addr_i,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    output logic            redirect_v_o,
    output logic [ADDR-1:0] redirect_addr_o,
    output logic            flush_if_o,
    output logic            flush_id_o,
    output logic            flush_ex_o,
    output logic            busy_o
`ifdef BRANCH_CTRL_STATS_EN
    ,
    output logic [31:0]     taken_cnt_o
`endif
);

    localparam logic [BC_CNT_W-1:0] DRAIN_LD =
        BC_CNT_W'(DRAIN_CYCLES);

    bc_state_t state_q;
    bc_state_t state_d;
    logic      accept;
    logic      cnt_load;
    logic      cnt_dec;
    logic      cnt_zero;
    logic      cnt_last;
    logic      flush_q;

    assign accept = (state_q == IDLE) && branch_i && !stall_i;

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = REDIRECT;
            end
            REDIRECT: begin
                if (fetch_ready_i) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DRAIN;
                        cnt_load = 1'b1;
                    end
                end
            end
            DRAIN: begin
                cnt_dec = 1'b1;
                // zero is a safety exit; normal exit is on the last count
                if (cnt_last || cnt_zero) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    branch_drain_cnt #(
        .W (BC_CNT_W)
    ) u_drain_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (DRAIN_LD),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    // Outputs are registered from the next state, not decoded from state_q
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            redirect_v_o    <= 1'b0;
            redirect_addr_o <= '0;
            flush_q         <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            state_q      <= state_d;
            redirect_v_o <= (state_d == REDIRECT);
            flush_q      <= (state_d != IDLE);
            busy_o       <= (state_d != IDLE);
            if (accept) redirect_addr_o <= branch_addr_i;
        end
    end

    assign flush_if_o = flush_q;
    assign flush_id_o = flush_q;
    assign flush_ex_o = flush_q;

`ifdef BRANCH_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_o <= '0;
        end else if (accept) begin
            taken_cnt_o <= taken_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: drain=2 and drain=0 instances vs a model.
// Build with BRANCH_CTRL_STATS_EN to also check the taken counter.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        stall_i;
    logic        fetch_ready_i;

    logic        rv_a, fi_a, fd_a, fe_a, bz_a;
    logic [31:0] ra_a;
    logic        rv_b, fi_b, fd_b, fe_b, bz_b;
    logic [31:0] ra_b;
`ifdef BRANCH_CTRL_STATS_EN
    logic [31:0] cnt_a, cnt_b;
`endif

    logic [36:0] obs_a;
    logic [36:0] obs_b;
    assign obs_a = {rv_a, ra_a, fi_a, fd_a, fe_a, bz_a};
    assign obs_b = {rv_b, ra_b, fi_b, fd_b, fe_b, bz_b};

    always #5 clk = ~clk;

    branch_ctrl #(.ADDR(32), .DRAIN_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst),
        .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
        .redirect_v_o(rv_a), .redirect_addr_o(ra_a),
        .flush_if_o(fi_a), .flush_id_o(fd_a),
        .flush_ex_o(fe_a), .busy_o(bz_a)
`ifdef BRANCH_CTRL_STATS_EN
        , .taken_cnt_o(cnt_a)
`endif
    );

    branch_ctrl #(.ADDR(32), .DRAIN_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
        .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
        .redirect_v_o(rv_b), .redirect_addr_o(ra_b),
        .flush_if_o(fi_b), .flush_id_o(fd_b),
        .flush_ex_o(fe_b), .busy_o(bz_b)
`ifdef BRANCH_CTRL_STATS_EN
        , .taken_cnt_o(cnt_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: a pending redirect flag plus the number of bubble cycles left
    int          dcfg[2] = '{2, 0};
    bit          pend[2];
    int          left[2];
    logic [31:0] maddr[2];
    logic [31:0] mcnt[2];

    function automatic logic [36:0] expv(input int i);
        logic f;
        f = pend[i] || (left[i] > 0);
        return {pend[i], maddr[i], f, f, f, f};
    endfunction

    task automatic step(input logic r, input logic br,
                        input logic [31:0] a,
                        input logic st, input logic rdy);
        rst = r; branch_i = br; branch_addr_i = a;
        stall_i = st; fetch_ready_i = rdy;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                pend[i] = 0; left[i] = 0;
                maddr[i] = '0; mcnt[i] = '0;
            end else if (pend[i]) begin
                if (rdy) begin
                    pend[i] = 0;
                    left[i] = dcfg[i];
                end
            end else if (left[i] > 0) begin
                left[i]--;
            end else if (br && !st) begin
                pend[i] = 1;
                maddr[i] = a;
                mcnt[i] = mcnt[i] + 32'd1;
            end
        end
        #1;
    endtask

    task automatic go_idle();
        for (int k = 0; k < 4; k++) step(0, 0, $urandom, 0, 1);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1, 1, $urandom, 1'($urandom_range(0, 1)), 1);
            checks++;
            if (obs_a !== 37'd0) begin
                errors++;
                $display("FAIL reset_a got=%h want=0", obs_a);
            end
            checks++;
            if (obs_b !== 37'd0) begin
                errors++;
                $display("FAIL reset_b got=%h want=0", obs_b);
            end
`ifdef BRANCH_CTRL_STATS_EN
            checks++;
            if (cnt_a !== 32'd0) begin
                errors++;
                $display("FAIL reset_cnt got=%0d want=0", cnt_a);
            end
`endif
        end
    endtask

    task automatic test_basic();
        int fl_a, fl_b, rv_n;
        fl_a = 0; fl_b = 0; rv_n = 0;
        step(0, 1, 32'h0000_0100, 0, 1);
        checks++;
        if (rv_a !== 1'b1 || ra_a !== 32'h100) begin
            errors++;
            $display("FAIL basic_cap got=%b/%h want=1/100",
                     rv_a, ra_a);
        end
        for (int k = 0; k < 6; k++) begin
            fl_a += int'(fi_a); fl_b += int'(fi_b);
            rv_n += int'(rv_a);
            checks++;
            if (obs_a !== expv(0)) begin
                errors++;
                $display("FAIL basic_a got=%h want=%h",
                         obs_a, expv(0));
            end
            step(0, 0, $urandom, 0, 1);
        end
        checks++;
        if (fl_a != 3 || rv_n != 1) begin
            errors++;
            $display("FAIL basic_len got=%0d/%0d want=3/1",
                     fl_a, rv_n);
        end
        checks++;
        if (fl_b != 1) begin
            errors++;
            $display("FAIL basic_zero got=%0d want=1", fl_b);
        end
    endtask

    task automatic test_backpressure();
        int held;
        held = 0;
        step(0, 1, 32'h0000_0200, 0, 0);
        held += int'(rv_a && ra_a == 32'h200);
        for (int k = 0; k < 4; k++) begin
            step(0, 1'($urandom), $urandom,
                 1'($urandom_range(0, 1)), 0);
            held += int'(rv_a && ra_a == 32'h200);
            checks++;
            if (obs_a !== expv(0)) begin
                errors++;
                $display("FAIL bp_a got=%h want=%h",
                         obs_a, expv(0));
            end
        end
        checks++;
        if (held != 5) begin
            errors++;
            $display("FAIL bp_hold got=%0d want=5", held);
        end
        step(0, 0, $urandom, 0, 1);
        checks++;
        if (rv_a !== 1'b0 || fi_a !== 1'b1 || bz_a !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain got=%b%b%b want=011",
                     rv_a, fi_a, bz_a);
        end
        go_idle();
    endtask

    task automatic test_masking();
        logic [31:0] c0;
        c0 = mcnt[0];
        step(0, 1, 32'h0000_0300, 0, 1);
        step(0, 0, $urandom, 0, 1);
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 32'hDEAD_0000, 0, 1);
            checks++;
            if (obs_a !== expv(0)) begin
                errors++;
                $display("FAIL mask_a got=%h want=%h",
                         obs_a, expv(0));
            end
            checks++;
            if (obs_b !== expv(1)) begin
                errors++;
                $display("FAIL mask_b got=%h want=%h",
                         obs_b, expv(1));
            end
        end
        step(0, 0, $urandom, 0, 1);
        checks++;
        if (ra_a !== 32'h300 || rv_a !== 1'b0 || bz_a !== 1'b0) begin
            errors++;
            $display("FAIL mask_addr got=%h/%b want=300/0",
                     ra_a, rv_a);
        end
`ifdef BRANCH_CTRL_STATS_EN
        checks++;
        if (cnt_a !== c0 + 32'd1) begin
            errors++;
            $display("FAIL mask_cnt got=%0d want=%0d",
                     cnt_a, c0 + 32'd1);
        end
`else
        c0 = c0 + 32'd0;
`endif
        go_idle();
    endtask

    task automatic test_stall();
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 32'h0000_0400, 1, 0);
            checks++;
            if (rv_a !== 1'b0 || bz_a !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold got=%b%b want=00",
                         rv_a, bz_a);
            end
        end
        step(0, 1, 32'h0000_0400, 0, 0);
        checks++;
        if (rv_a !== 1'b1 || ra_a !== 32'h400) begin
            errors++;
            $display("FAIL stall_cap got=%b/%h want=1/400",
                     rv_a, ra_a);
        end
        go_idle();
    endtask

    task automatic test_reset_mid_drain();
        step(0, 1, 32'h0000_0500, 0, 1);
        step(0, 0, $urandom, 0, 1);
        step(1, 1, $urandom, 0, 1);
        checks++;
        if (obs_a !== 37'd0) begin
            errors++;
            $display("FAIL rst_drain got=%h want=0", obs_a);
        end
        step(0, 1, 32'h0000_0040, 0, 1);
        checks++;
        if (rv_a !== 1'b1 || ra_a !== 32'h40 || fi_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_next got=%b/%h want=1/40",
                     rv_a, ra_a);
        end
        go_idle();
    endtask

    task automatic test_zero_drain();
        int fl, rv;
        fl = 0; rv = 0;
        step(0, 1, 32'h0000_0600, 0, 0);
        fl += int'(fi_b); rv += int'(rv_b);
        step(0, 0, $urandom, 0, 0);
        fl += int'(fi_b); rv += int'(rv_b);
        step(0, 0, $urandom, 0, 1);
        checks++;
        if (fi_b !== 1'b0 || bz_b !== 1'b0 || rv_b !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle got=%b%b%b want=000",
                     rv_b, fi_b, bz_b);
        end
        checks++;
        if (fl != 2 || rv != 2) begin
            errors++;
            $display("FAIL zero_len got=%0d/%0d want=2/2", fl, rv);
        end
        go_idle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 49) == 0),
                 1'($urandom), $urandom,
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 2) != 0));
            checks++;
            if (obs_a !== expv(0)) begin
                errors++;
                $display("FAIL rand_a got=%h want=%h",
                         obs_a, expv(0));
            end
            checks++;
            if (obs_b !== expv(1)) begin
                errors++;
                $display("FAIL rand_b got=%h want=%h",
                         obs_b, expv(1));
            end
`ifdef BRANCH_CTRL_STATS_EN
            checks++;
            if (cnt_a !== mcnt[0] || cnt_b !== mcnt[1]) begin
                errors++;
                $display("FAIL rand_cnt got=%0d/%0d want=%0d/%0d",
                         cnt_a, cnt_b, mcnt[0], mcnt[1]);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; branch_i = 1'b0; branch_addr_i = '0;
        stall_i = 1'b0; fetch_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; left[i] = 0;
            maddr[i] = '0; mcnt[i] = '0;
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_masking();
        test_stall();
        test_reset_mid_drain();
        test_zero_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
